// File: rtl/muldiv_iter.sv
// Iterative 32-cycle multiply/divide unit with architectural HI/LO.
// Ports: clk, rst (sync, active-low), pause, op/start/a/b in; busy, done, hi, lo out.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause,
  input  logic [3:0]       op,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  // mul: {partial product, remaining multiplier}
  // div: {partial remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_p_q, neg_p_d;
  logic               neg_r_q, neg_r_d;

  logic               sgn_op;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     sh;
  logic               ge;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;

  always_comb begin
    sgn_op = (op == 4'd1) || (op == 4'd3);
    a_neg  = sgn_op & a[WIDTH-1];
    b_neg  = sgn_op & b[WIDTH-1];
    abs_a  = a_neg ? -a : a;
    abs_b  = b_neg ? -b : b;
    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
           + (acc_q[0] ? {1'b0, opnd_q} : '0);
    sh     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    ge     = sh >= {1'b0, opnd_q};
    // remainder stays below divisor, so the difference fits WIDTH bits
    diff   = sh[WIDTH-1:0] - opnd_q;
    prod_s = neg_p_q ? -acc_q : acc_q;
    quo_s  = neg_p_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_s  = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH]
                     : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (op >= 4'd1 && op <= 4'd4) begin
            is_div_d = op[2] | (op == 4'd3);
            neg_p_d  = a_neg ^ b_neg;
            neg_r_d  = a_neg;
            cnt_d    = '0;
            busy_d   = 1'b1;
            state_d  = RUN;
            if (op >= 4'd3) begin
              acc_d  = {{WIDTH{1'b0}}, abs_a};
              opnd_d = abs_b;
            end else begin
              acc_d  = {{WIDTH{1'b0}}, abs_b};
              opnd_d = abs_a;
            end
          end else if (op == 4'd5) begin
            hi_d = a;
          end else if (op == 4'd6) begin
            lo_d = a;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div_q) begin
          if (ge)
            acc_d = {diff, acc_q[WIDTH-2:0], 1'b1};
          else
            acc_d = {sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(WIDTH - 1))
          state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          // divide by zero: remainder correction restores a, quotient all-ones
          lo_d = (opnd_q == '0) ? '1 : quo_s;
          hi_d = rem_s;
        end else begin
          hi_d = prod_s[2*WIDTH-1:WIDTH];
          lo_d = prod_s[WIDTH-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
    end else if (!pause) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Testbench for muldiv_iter: vector table, corner sequences, random vs model.
// Drives at negedge, samples at negedge.
module tb_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pause = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  muldiv_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .pause(pause), .op(op), .start(start),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic void model(input logic [3:0] o, input logic [31:0] x,
                                input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    eh = '0;
    el = '0;
    case (o)
      4'd1: begin p = 64'(sx * sy); eh = p[63:32]; el = p[31:0]; end
      4'd2: begin p = {32'b0, x} * {32'b0, y}; eh = p[63:32]; el = p[31:0]; end
      4'd3, 4'd4: begin
        if (y == 0) begin
          eh = x; el = '1;
        end else if (o == 4'd3) begin
          q = sx / sy; r = sx % sy; el = q[31:0]; eh = r[31:0];
        end else begin
          el = x / y; eh = x % y;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input string name, input logic [3:0] o,
                     input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] eh, input logic [31:0] el,
                     input int pause_at, input int pause_len,
                     input int inj_at);
    int edges, dones, gaps;
    logic [31:0] ph, pl;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0; op = 4'd0;
    edges = 0; dones = 0; gaps = 0;
    ph = hi; pl = lo;
    while (edges < 100 && dones == 0) begin
      pause = (pause_len > 0) && (edges >= pause_at)
              && (edges < pause_at + pause_len);
      if (edges == inj_at) begin
        start = 1'b1; op = 4'd1; a = $urandom; b = $urandom;
      end else begin
        start = 1'b0; op = 4'd0;
      end
      tick();
      edges++;
      if (done) dones++;
      else begin
        if (!busy) gaps++;
        if (hi !== ph || lo !== pl) gaps++;
      end
    end
    pause = 1'b0; start = 1'b0; op = 4'd0;
    chk({name, " latency"}, edges, 33 + pause_len);
    chk({name, " busy/holds"}, gaps, 0);
    chk({name, " busy at done"}, {31'b0, busy}, 0);
    chk({name, " hi"}, hi, eh);
    chk({name, " lo"}, lo, el);
    tick();
    chk({name, " done pulse width"}, {31'b0, done}, 0);
  endtask

  initial begin
    logic [31:0] eh, el, sh, sl, x, y;
    logic [3:0]  o;
    int nd;

    vecs[0] = '{4'd1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1};
    vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{4'd4, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF};
    vecs[4] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000};
    vecs[5] = '{4'd3, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF};

    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("reset busy", {31'b0, busy}, 0);
    chk("reset done", {31'b0, done}, 0);
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);

    op = 4'd5; a = 32'h12345678; start = 1'b1;
    tick();
    chk("mthi hi", hi, 32'h12345678);
    op = 4'd6; a = 32'h9ABCDEF0;
    tick();
    start = 1'b0; op = 4'd0;
    chk("mtlo lo", lo, 32'h9ABCDEF0);
    chk("mthi hi kept", hi, 32'h12345678);
    chk("mt busy", {31'b0, busy}, 0);
    chk("mt done", {31'b0, done}, 0);

    op = 4'd9; a = 32'h55; b = 32'h3; start = 1'b1;
    tick();
    start = 1'b0; op = 4'd0;
    tick();
    chk("noop busy", {31'b0, busy}, 0);
    chk("noop hi", hi, 32'h12345678);
    chk("noop lo", lo, 32'h9ABCDEF0);

    for (int i = 0; i < 6; i++)
      run($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
          vecs[i].eh, vecs[i].el, 0, 0, -1);

    run("pause divu", 4'd4, 32'd1000, 32'd7, 32'd6, 32'd142, 10, 5, -1);

    model(4'd4, 32'hDEADBEEF, 32'h1234, eh, el);
    run("busy start", 4'd4, 32'hDEADBEEF, 32'h1234, eh, el, 0, 0, 20);
    nd = 0;
    repeat (40) begin
      tick();
      if (done || busy) nd++;
    end
    chk("busy start no extra", nd, 0);

    // reset in the middle of a MULT
    op = 4'd1; a = 32'd123; b = 32'd456; start = 1'b1;
    tick();
    start = 1'b0; op = 4'd0;
    repeat (15) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst busy", {31'b0, busy}, 0);
    chk("midrst hi", hi, 0);
    chk("midrst lo", lo, 0);
    nd = 0;
    repeat (40) begin
      if (done || busy) nd++;
      tick();
    end
    chk("midrst no done", nd, 0);
    run("after rst", 4'd1, 32'd123, 32'd456, 32'd0, 32'd56088, 0, 0, -1);

    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(1, 4));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 7) == 0) y = 0;
      if ($urandom_range(0, 7) == 0) x = 32'h80000000;
      if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(1, 300));
      model(o, x, y, eh, el);
      sh = hi; sl = lo;
      if (sh === 32'hx || sl === 32'hx) $display("FAIL rnd%0d x state", i);
      run($sformatf("rnd%0d op%0d", i, o), o, x, y, eh, el, 0, 0, -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
